w_fetch_unit: RTL and testbench

- Weight fetch engine directly upstream of the weight controller.
- On the controller's w_read/clr_w it reads ROWS weight rows from the on-chip weight buffer.
- Each returned row is presented to the systolic array's shadow weight registers with a row select.
- Raises w_done once the full tile is loaded; the controller then issues switch/start_if.

---
 rtl/cnn_pkg.sv | 21 ++
 rtl/w_fetch_unit_if.sv | 39 +++
 rtl/w_fetch_unit.sv | 106 ++++++++++
 tb/tb_w_fetch_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared definitions for the weight-fetch datapath.
// - Default array geometry (rows, columns, element width, buffer address width).
// - fetch_state_t: weight-fetch FSM encoding.
// - w_row_t: one packed weight row at the default geometry.
package cnn_pkg;

  localparam int unsigned ROWS_DEF = 16;
  localparam int unsigned COLS_DEF = 16;
  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned AW_DEF   = 12;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } fetch_state_t;

  typedef logic [COLS_DEF*DW_DEF-1:0] w_row_t;

endpackage

// File: rtl/w_fetch_unit_if.sv
// w_fetch_unit_if: controller, weight-buffer and shadow-register signals of the
// weight fetch unit.
// - w_read, clr_w, base_addr : controller -> fetch unit
// - mem_rd_en, mem_addr      : fetch unit -> weight buffer
// - mem_rd_data              : weight buffer -> fetch unit (1 cycle after mem_rd_en)
// - w_row_valid/sel/data     : fetch unit -> systolic array shadow registers
// - w_done                   : fetch unit -> controller
// Modport slave is the fetch unit; master is its surroundings.
interface w_fetch_unit_if #(
  parameter int unsigned ROWS = cnn_pkg::ROWS_DEF,
  parameter int unsigned COLS = cnn_pkg::COLS_DEF,
  parameter int unsigned DW   = cnn_pkg::DW_DEF,
  parameter int unsigned AW   = cnn_pkg::AW_DEF
);

  localparam int unsigned SelW = $clog2(ROWS);

  logic                 w_read;
  logic                 clr_w;
  logic [AW-1:0]        base_addr;
  logic                 mem_rd_en;
  logic [AW-1:0]        mem_addr;
  logic [COLS*DW-1:0]   mem_rd_data;
  logic                 w_row_valid;
  logic [SelW-1:0]      w_row_sel;
  logic [COLS*DW-1:0]   w_row_data;
  logic                 w_done;

  modport master (
    output w_read, clr_w, base_addr, mem_rd_data,
    input  mem_rd_en, mem_addr, w_row_valid, w_row_sel, w_row_data, w_done
  );

  modport slave (
    input  w_read, clr_w, base_addr, mem_rd_data,
    output mem_rd_en, mem_addr, w_row_valid, w_row_sel, w_row_data, w_done
  );

endinterface

// File: rtl/w_fetch_unit.sv
// w_fetch_unit: fetches one ROWS x COLS weight tile from the on-chip weight
// buffer and streams it row by row into the systolic array shadow registers.
// Ports:
// - clk   : clock
// - rst   : synchronous active-low reset
// - fu_io : w_fetch_unit_if.slave (controller, buffer and shadow-register side)
// A clr_w&w_read restarts the tile from base_addr; reads are issued in FETCH
// while w_read is high, returns are presented one cycle later, and w_done is
// held once the last row has been presented.
module w_fetch_unit import cnn_pkg::*; #(
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned COLS = COLS_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned AW   = AW_DEF
) (
  input logic            clk,
  input logic            rst,
  w_fetch_unit_if.slave  fu_io
);

  localparam int unsigned CntW = $clog2(ROWS + 1);
  localparam int unsigned SelW = $clog2(ROWS);
  localparam logic [CntW-1:0] LastRow = CntW'(ROWS - 1);

  fetch_state_t    state_q, state_d;
  logic [CntW-1:0] iss_cnt_q, iss_cnt_d;
  logic [CntW-1:0] ret_cnt_q, ret_cnt_d;
  logic [AW-1:0]   base_q, base_d;
  logic            inflight_q, inflight_d;

  logic clr;
  logic rd_en;
  logic ret_valid;

  // clr_w is only meaningful while w_read is high.
  assign clr = fu_io.w_read & fu_io.clr_w;

  // Reads never share a cycle with a restart, so every read in flight across a
  // clr cycle returns in that clr cycle and is dropped there as stale.
  assign rd_en     = rst & (state_q == FETCH) & fu_io.w_read & ~clr;
  assign ret_valid = rst & inflight_q & ~clr;

  assign fu_io.mem_rd_en   = rd_en;
  assign fu_io.mem_addr    = rd_en ? base_q + AW'(iss_cnt_q) : '0;
  assign fu_io.w_row_valid = ret_valid;
  assign fu_io.w_row_sel   = ret_valid ? ret_cnt_q[SelW-1:0] : '0;
  assign fu_io.w_row_data  = ret_valid ? fu_io.mem_rd_data : '0;
  assign fu_io.w_done      = rst & (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    iss_cnt_d  = iss_cnt_q;
    ret_cnt_d  = ret_cnt_q;
    base_d     = base_q;
    inflight_d = rd_en;

    if (ret_valid) begin
      ret_cnt_d = ret_cnt_q + CntW'(1);
    end

    unique case (state_q)
      FETCH: begin
        if (rd_en) begin
          iss_cnt_d = iss_cnt_q + CntW'(1);
          if (iss_cnt_q == LastRow) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (ret_valid && (ret_cnt_q == LastRow)) begin
          state_d = DONE;
        end
      end
      IDLE, DONE: begin
      end
      default: begin
      end
    endcase

    // Restart wins over everything else in every state.
    if (clr) begin
      base_d    = fu_io.base_addr;
      iss_cnt_d = '0;
      ret_cnt_d = '0;
      state_d   = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      iss_cnt_q  <= '0;
      ret_cnt_q  <= '0;
      base_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      iss_cnt_q  <= iss_cnt_d;
      ret_cnt_q  <= ret_cnt_d;
      base_q     <= base_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_w_fetch_unit.sv
// tb_w_fetch_unit: directed bench for w_fetch_unit with a one-cycle-latency
// weight buffer model whose row data encodes the read address.
module tb_w_fetch_unit;
  import cnn_pkg::*;

  localparam int unsigned ROWS = 16;
  localparam int unsigned COLS = 16;
  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 12;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  w_fetch_unit_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) fu_if ();

  w_fetch_unit #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .fu_io (fu_if)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int nv;

  // Row contents: the 12-bit address tagged with 4'hA, repeated across the row.
  function automatic w_row_t pat(input logic [AW-1:0] a);
    return {8{4'hA, a}};
  endfunction

  always @(posedge clk) begin
    fu_if.mem_rd_data <= fu_if.mem_rd_en ? pat(fu_if.mem_addr) : '0;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then let outputs settle.
  task automatic cyc(input logic r, input logic wr, input logic cl, input logic [AW-1:0] b);
    @(posedge clk);
    #1;
    rst             = r;
    fu_if.w_read    = wr;
    fu_if.clr_w     = cl;
    fu_if.base_addr = b;
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic e_rd, input logic [AW-1:0] e_addr,
                            input logic e_v, input logic [3:0] e_sel,
                            input logic [AW-1:0] e_raddr, input logic e_done);
    chk({tag, " rd_en"}, fu_if.mem_rd_en, e_rd);
    if (e_rd) chk({tag, " addr"}, fu_if.mem_addr, e_addr);
    chk({tag, " valid"}, fu_if.w_row_valid, e_v);
    if (e_v) begin
      chk({tag, " sel"}, fu_if.w_row_sel, e_sel);
      chk({tag, " data"}, fu_if.w_row_data, pat(e_raddr));
    end
    chk({tag, " done"}, fu_if.w_done, e_done);
  endtask

  initial begin
    rst             = 1'b0;
    fu_if.w_read    = 1'b0;
    fu_if.clr_w     = 1'b0;
    fu_if.base_addr = '0;

    // Reset for 3 cycles with w_read high, then idle without a restart.
    for (int t = 0; t < 3; t++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      expect_cyc($sformatf("rst t%0d", t), 1'b0, '0, 1'b0, '0, '0, 1'b0);
      chk($sformatf("rst t%0d sel", t), fu_if.w_row_sel, 4'd0);
      chk($sformatf("rst t%0d data", t), fu_if.w_row_data, 128'd0);
      chk($sformatf("rst t%0d addr", t), fu_if.mem_addr, 12'd0);
    end
    for (int t = 0; t < 2; t++) begin
      cyc(1'b1, 1'b1, 1'b0, '0);
      expect_cyc($sformatf("idle t%0d", t), 1'b0, '0, 1'b0, '0, '0, 1'b0);
    end

    // Nominal tile at 0x100: issues t1..t16, valids t2..t17, done from t18.
    cyc(1'b1, 1'b1, 1'b1, 12'h100);
    expect_cyc("nom t0", 1'b0, '0, 1'b0, '0, '0, 1'b0);
    for (int t = 1; t <= 17; t++) begin
      cyc(1'b1, 1'b1, 1'b0, '0);
      expect_cyc($sformatf("nom t%0d", t), t <= 16, 12'h100 + AW'(t - 1),
                 t >= 2, 4'(t - 2), 12'h100 + AW'(t - 2), 1'b0);
    end
    for (int t = 18; t <= 21; t++) begin
      cyc(1'b1, t < 20, 1'b0, '0);
      expect_cyc($sformatf("nom t%0d", t), 1'b0, '0, 1'b0, '0, '0, 1'b1);
    end

    // Stall: w_read low on t6..t8 after 5 issues; done moves out to t21.
    cyc(1'b1, 1'b1, 1'b1, 12'h100);
    expect_cyc("stall t0", 1'b0, '0, 1'b0, '0, '0, 1'b1);
    for (int t = 1; t <= 22; t++) begin
      logic wr;
      int   irow;
      int   vrow;
      wr   = !(t >= 6 && t <= 8);
      irow = (t <= 5) ? t - 1 : t - 4;
      vrow = (t <= 6) ? t - 2 : t - 5;
      cyc(1'b1, wr, wr ? 1'b0 : 1'bx, '0);
      expect_cyc($sformatf("stall t%0d", t),
                 (t >= 1 && t <= 5) || (t >= 9 && t <= 19), 12'h100 + AW'(irow),
                 (t >= 2 && t <= 6) || (t >= 10 && t <= 20), 4'(vrow),
                 12'h100 + AW'(vrow), t >= 21);
    end

    // Abort: restart at 0x200 while row 7 is returning; row 7 is dropped.
    cyc(1'b1, 1'b1, 1'b1, 12'h100);
    expect_cyc("abort t0", 1'b0, '0, 1'b0, '0, '0, 1'b1);
    for (int t = 1; t <= 8; t++) begin
      cyc(1'b1, 1'b1, 1'b0, '0);
      expect_cyc($sformatf("abort t%0d", t), 1'b1, 12'h100 + AW'(t - 1),
                 t >= 2, 4'(t - 2), 12'h100 + AW'(t - 2), 1'b0);
    end
    cyc(1'b1, 1'b1, 1'b1, 12'h200);
    expect_cyc("abort clr", 1'b0, '0, 1'b0, '0, '0, 1'b0);
    nv = 0;
    for (int u = 1; u <= 19; u++) begin
      cyc(1'b1, 1'b1, 1'b0, '0);
      if (fu_if.w_row_valid) nv++;
      expect_cyc($sformatf("abort u%0d", u), u <= 16, 12'h200 + AW'(u - 1),
                 u >= 2 && u <= 17, 4'(u - 2), 12'h200 + AW'(u - 2), u >= 18);
    end
    chk("abort valid count", nv, 16);

    // Address wrap from 0xFF8.
    cyc(1'b1, 1'b1, 1'b1, 12'hFF8);
    expect_cyc("wrap t0", 1'b0, '0, 1'b0, '0, '0, 1'b1);
    for (int t = 1; t <= 18; t++) begin
      cyc(1'b1, 1'b1, 1'b0, '0);
      expect_cyc($sformatf("wrap t%0d", t), t <= 16, 12'hFF8 + AW'(t - 1),
                 t >= 2 && t <= 17, 4'(t - 2), 12'hFF8 + AW'(t - 2), t >= 18);
      if (t == 9) chk("wrap t9 addr zero", fu_if.mem_addr, 12'h000);
      if (t == 16) chk("wrap t16 addr", fu_if.mem_addr, 12'h007);
    end

    // Reset in the cycle the last row returns.
    cyc(1'b1, 1'b1, 1'b1, 12'h100);
    expect_cyc("rdrain t0", 1'b0, '0, 1'b0, '0, '0, 1'b1);
    for (int t = 1; t <= 16; t++) begin
      cyc(1'b1, 1'b1, 1'b0, '0);
      expect_cyc($sformatf("rdrain t%0d", t), 1'b1, 12'h100 + AW'(t - 1),
                 t >= 2, 4'(t - 2), 12'h100 + AW'(t - 2), 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0, '0);
    expect_cyc("rdrain t17", 1'b0, '0, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    expect_cyc("rdrain t18", 1'b0, '0, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, '0);
    expect_cyc("rdrain t19 idle", 1'b0, '0, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 12'h300);
    expect_cyc("rdrain t20 clr", 1'b0, '0, 1'b0, '0, '0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, '0);
    expect_cyc("rdrain t21", 1'b1, 12'h300, 1'b0, '0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
